// File: rtl/mips.sv
// Single-cycle MIPS subset core (lw/sw/R-type/addi/beq/j) with word-addressed
// instruction and data RAMs and a debug register read port.

module mips_ram #(
  parameter int DEPTH = 256
) (
  input  logic        clock,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] memory [DEPTH];
  logic [29:0] word;
  logic [AW-1:0] idx;
  logic unused_addr_bits;

  // byte address -> word index, wrapping at the RAM depth
  assign word = addr[31:2] % 30'(DEPTH);
  assign idx = word[AW-1:0];
  assign unused_addr_bits = ^{addr[1:0], word[29:AW]};

  always_ff @(posedge clock) begin
    if (we) memory[idx] <= wdata;
  end

  assign rdata = memory[idx];
endmodule

module mips_fetch #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  mips_ram #(.DEPTH(IMEM_WORDS)) instr_ram (
    .clock (clock),
    .we    (1'b0),
    .addr  (pc),
    .wdata (32'd0),
    .rdata (instr)
  );
endmodule

module mips_memory #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  mips_ram #(.DEPTH(DMEM_WORDS)) data_ram (
    .clock (clock),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );
endmodule

module mips_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  input  logic [4:0]  raddr_dbg,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] rdata_dbg
);
  logic [31:0] registers [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata_a   = (raddr_a == 5'd0)   ? 32'd0 : registers[raddr_a];
  assign rdata_b   = (raddr_b == 5'd0)   ? 32'd0 : registers[raddr_b];
  assign rdata_dbg = (raddr_dbg == 5'd0) ? 32'd0 : registers[raddr_dbg];
endmodule

module mips #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  reg_out_id,
  output logic [31:0] reg_out_data,
  input  logic        fetch_ram_load,
  input  logic        mem_ram_load
);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] pc, pc_next, pc_plus4, pc_inc;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm;
  logic [31:0] rs_data, rt_data;
  logic [31:0] mem_addr, mem_rdata;
  logic        reg_we, mem_we, stall;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        unused_shamt;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign simm   = {{16{instr[15]}}, instr[15:0]};
  assign unused_shamt = ^instr[10:6];

  assign stall    = fetch_ram_load | mem_ram_load;
  assign pc_plus4 = pc + 32'd4;
  assign pc_inc   = (pc_plus4 >= IMEM_BYTES) ? 32'd0 : pc_plus4;
  assign mem_addr = rs_data + simm;

  mips_fetch #(.IMEM_WORDS(IMEM_WORDS)) FETCH (
    .clock (clock),
    .pc    (pc),
    .instr (instr)
  );

  // the stall and reset gates keep the core off the RAM while it is being loaded
  mips_memory #(.DMEM_WORDS(DMEM_WORDS)) MEMORY (
    .clock (clock),
    .we    (mem_we && !stall && !reset),
    .addr  (mem_addr),
    .wdata (rt_data),
    .rdata (mem_rdata)
  );

  mips_regfile REGISTERS (
    .clock     (clock),
    .reset     (reset),
    .we        (reg_we && !stall),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .raddr_a   (rs),
    .raddr_b   (rt),
    .raddr_dbg (reg_out_id),
    .rdata_a   (rs_data),
    .rdata_b   (rt_data),
    .rdata_dbg (reg_out_data)
  );

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wr_addr = rd;
    wr_data = 32'd0;
    pc_next = pc_inc;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  wr_data = rs_data + rt_data;
          FN_SUB:  wr_data = rs_data - rt_data;
          FN_AND:  wr_data = rs_data & rt_data;
          FN_OR:   wr_data = rs_data | rt_data;
          FN_SLT:  wr_data = {31'd0, $signed(rs_data) < $signed(rt_data)};
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we  = 1'b1;
        wr_addr = rt;
        wr_data = rs_data + simm;
      end
      OP_LW: begin
        reg_we  = 1'b1;
        wr_addr = rt;
        wr_data = mem_rdata;
      end
      OP_SW:  mem_we = 1'b1;
      OP_BEQ: if (rs_data == rt_data) pc_next = pc_plus4 + {simm[29:0], 2'b00};
      OP_J:   pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= 32'd0;
    else if (!stall) pc <= pc_next;
  end
endmodule

// File: tb/tb_mips.sv
// Directed-vector bench for the single-cycle MIPS core: programs are loaded
// through hierarchy, run for a fixed number of cycles, then state is checked.

module tb_mips;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  reg_out_id = 5'd0;
  logic [31:0] reg_out_data;
  logic        fetch_ram_load = 1'b0;
  logic        mem_ram_load = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] prog [$];

  mips dut (
    .clock          (clock),
    .reset          (reset),
    .reg_out_id     (reg_out_id),
    .reg_out_data   (reg_out_data),
    .fetch_ram_load (fetch_ram_load),
    .mem_ram_load   (mem_ram_load)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  // hold reset and both load strobes while memories are rewritten
  task automatic load_prog();
    reset = 1'b1;
    fetch_ram_load = 1'b1;
    mem_ram_load = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.FETCH.instr_ram.memory[i] = 32'd0;
      dut.MEMORY.data_ram.memory[i] = 32'd0;
    end
    foreach (prog[i]) dut.FETCH.instr_ram.memory[i] = prog[i];
  endtask

  task automatic start();
    @(negedge clock);
    fetch_ram_load = 1'b0;
    mem_ram_load = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_r5", dut.REGISTERS.registers[5], 32'd0);

    // load/store
    prog = '{i_op(8'h23, 0, 18, 8), i_op(8'h23, 0, 19, 8), i_op(8'h2B, 0, 18, 12)};
    load_prog();
    dut.MEMORY.data_ram.memory[2] = 32'd5;
    start();
    run(3);
    check("lw_r18", dut.REGISTERS.registers[18], 32'd5);
    check("lw_r19", dut.REGISTERS.registers[19], 32'd5);
    check("sw_dmem3", dut.MEMORY.data_ram.memory[3], 32'd5);
    check("ls_pc", dut.pc, 32'd12);

    // ALU plus unimplemented funct / opcode acting as NOP
    prog = '{i_op(8, 0, 1, 7), i_op(8, 0, 2, -3), r_op(1, 2, 3, 'h20), r_op(2, 1, 4, 'h2A),
             r_op(1, 2, 5, 'h22), r_op(1, 2, 6, 'h24), r_op(1, 2, 7, 'h25), r_op(1, 2, 8, 'h2A),
             r_op(1, 2, 10, 'h21), i_op('h3F, 0, 11, 5)};
    load_prog();
    start();
    run(10);
    reg_out_id = 5'd3;
    #1;
    check("dbg_r3", reg_out_data, 32'd4);
    check("slt_r4", dut.REGISTERS.registers[4], 32'd1);
    check("sub_r5", dut.REGISTERS.registers[5], 32'd10);
    check("and_r6", dut.REGISTERS.registers[6], 32'd5);
    check("or_r7", dut.REGISTERS.registers[7], 32'hFFFF_FFFF);
    check("slt_r8", dut.REGISTERS.registers[8], 32'd0);
    check("addi_r2", dut.REGISTERS.registers[2], 32'hFFFF_FFFD);
    check("nop_funct_r10", dut.REGISTERS.registers[10], 32'd0);
    check("nop_op_r11", dut.REGISTERS.registers[11], 32'd0);
    check("nop_pc", dut.pc, 32'd40);

    // zero register
    prog = '{i_op(8, 0, 0, 9), i_op(8, 0, 9, 1)};
    load_prog();
    start();
    run(2);
    reg_out_id = 5'd0;
    #1;
    check("dbg_r0", reg_out_data, 32'd0);
    check("reg0", dut.REGISTERS.registers[0], 32'd0);
    check("after_r0_r9", dut.REGISTERS.registers[9], 32'd1);

    // branches and jump
    prog = '{i_op(8, 0, 1, 1), i_op(4, 0, 0, 1), i_op(8, 0, 2, 5), i_op(4, 1, 0, 1),
             i_op(8, 0, 3, 3), j_op(0)};
    load_prog();
    start();
    run(5);
    check("jump_pc", dut.pc, 32'd0);
    check("beq_skip_r2", dut.REGISTERS.registers[2], 32'd0);
    check("beq_nt_r3", dut.REGISTERS.registers[3], 32'd3);
    run(1);
    check("after_jump_pc", dut.pc, 32'd4);

    // stall via mem_ram_load
    prog = '{i_op(8, 0, 1, 42), i_op('h2B, 0, 1, 0), i_op('h2B, 0, 1, 4), i_op(8, 0, 2, 1)};
    load_prog();
    start();
    run(1);
    mem_ram_load = 1'b1;
    run(3);
    check("stall_pc", dut.pc, 32'd4);
    check("stall_dmem0", dut.MEMORY.data_ram.memory[0], 32'd0);
    check("stall_r1", dut.REGISTERS.registers[1], 32'd42);
    mem_ram_load = 1'b0;
    run(3);
    check("resume_dmem0", dut.MEMORY.data_ram.memory[0], 32'd42);
    check("resume_dmem1", dut.MEMORY.data_ram.memory[1], 32'd42);
    check("resume_r2", dut.REGISTERS.registers[2], 32'd1);

    // asynchronous reset mid-run
    prog = '{i_op(8, 0, 1, 11), i_op(8, 0, 2, 22), i_op('h2B, 0, 1, 16), j_op(0)};
    load_prog();
    start();
    run(3);
    check("pre_rst_dmem4", dut.MEMORY.data_ram.memory[4], 32'd11);
    check("pre_rst_r2", dut.REGISTERS.registers[2], 32'd22);
    #2 reset = 1'b1;
    #1;
    reg_out_id = 5'd2;
    #1;
    check("rst_pc", dut.pc, 32'd0);
    check("rst_r1", dut.REGISTERS.registers[1], 32'd0);
    check("rst_dbg_r2", reg_out_data, 32'd0);
    check("rst_dmem4", dut.MEMORY.data_ram.memory[4], 32'd11);
    @(negedge clock);
    reset = 1'b0;
    run(1);
    check("post_rst_r1", dut.REGISTERS.registers[1], 32'd11);
    check("post_rst_pc", dut.pc, 32'd4);

    // PC wrap past last word and data address wrap
    prog = '{i_op(8, 0, 6, 99), i_op('h2B, 0, 6, 1032), j_op(255)};
    load_prog();
    dut.FETCH.instr_ram.memory[255] = i_op(8, 0, 5, 77);
    start();
    run(3);
    check("jump_hi_pc", dut.pc, 32'd1020);
    run(1);
    check("wrap_pc", dut.pc, 32'd0);
    check("wrap_r5", dut.REGISTERS.registers[5], 32'd77);
    check("wrap_dmem2", dut.MEMORY.data_ram.memory[2], 32'd99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mips.md
MIPS -- requirements
Module: mips

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears PC and register file immediately.
REQ-003 SHALL have port: reg_out_id  input  5  debug register-file read index.
REQ-004 SHALL have port: reg_out_data  output  32  combinational contents of register reg_out_id; index 0 reads 0.
REQ-005 SHALL have port: fetch_ram_load  input  1  when 1, instruction RAM is being loaded externally; core stalls.
REQ-006 SHALL have port: mem_ram_load  input  1  when 1, data RAM is being loaded externally; core stalls.
REQ-007 SHALL have parameters: IMEM_WORDS, default 256, instruction RAM depth; DMEM_WORDS, default 256, data RAM depth.
REQ-008 SHALL expose bench-visible hierarchy: FETCH.instr_ram.memory[IMEM_WORDS] of 32-bit words; MEMORY.data_ram.memory[DMEM_WORDS] of 32-bit words; REGISTERS.registers[32] of 32-bit words.

Function
REQ-009 SHALL be single-cycle: one instruction fetched, executed and committed per rising clock edge.
REQ-010 SHALL fetch instruction instr_ram.memory[PC[31:2]] combinationally; PC is byte-addressed, word-aligned.
REQ-011 SHALL address data RAM by word: byte address A maps to data_ram.memory[A[31:2]], e.g. address 8 -> memory[2], 12 -> memory[3]; addresses above depth wrap modulo DMEM_WORDS.
REQ-012 SHALL implement lw (0x23) and sw (0x2B): address = rs + sign-extended imm16; lw writes rt, sw writes rt value to data RAM at the edge.
REQ-013 SHALL implement R-type (opcode 0) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), writing rd; arithmetic is 32-bit wrap-around, no overflow trap.
REQ-014 SHALL implement addi (0x08, sign-extended), beq (0x04, target = PC+4+(simm16<<2)), j (0x02, target = {PC+4[31:28], imm26, 2'b00}).
REQ-015 SHALL treat any other opcode/funct as NOP: PC+4, no register or memory write.
REQ-016 SHALL never modify register 0; reads of register 0 return 0.
REQ-017 SHALL read register file and data RAM combinationally; writes occur only at rising clock edge.
REQ-018 SHALL, while fetch_ram_load or mem_ram_load is 1, hold PC and suppress all register-file and data-RAM writes from the core.
REQ-019 SHALL wrap PC modulo IMEM_WORDS*4 when incrementing past the last word.

Reset
REQ-020 SHALL on reset=1 asynchronously set PC to 0 and all 32 registers to 0, holding them while reset is high.
REQ-021 SHALL NOT reset instruction or data RAM contents, so memories preloaded before or during reset survive.
REQ-022 SHALL resume fetching at address 0 on the first rising edge after reset deasserts; reset mid-instruction aborts that instruction's writes.

Verification
REQ-023 Load/store: dmem[2]=5, program lw $s2,8($0); lw $s3,8($0); sw $s2,12($0) -> after 3 cycles $s2(r18)=5, $s3(r19)=5, dmem[3]=5.
REQ-024 ALU: addi r1,r0,7; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=4, r4=1; reg_out_id=3 gives reg_out_data=4.
REQ-025 Zero register: addi r0,r0,9 -> reg_out_id=0 reads 0; REGISTERS.registers[0]=0.
REQ-026 Branch/jump: beq r0,r0,+1 skips next addi; j 0 returns PC to 0 -> skipped register unchanged.
REQ-027 Stall: assert mem_ram_load for 3 cycles during a sw sequence -> PC frozen, dmem unchanged; resumes on deassert.
REQ-028 Reset mid-run: pulse reset asynchronously between edges -> PC=0 and registers=0 immediately, dmem preserved.
